// File: rtl/cache_refill_controller.sv
// Refill/writeback sequencer for a 4-way set-associative cache. It runs one CPU
// request at a time: lookup, optional dirty-victim writeback, line refill, access.
module cache_refill_controller #(
  parameter int ADDRESS_WORD_SIZE = 32,
  parameter int TAG_SIZE          = 19,
  parameter int BLOCK_SIZE        = 16,
  parameter int NUMBER_OF_SETS    = 128
) (
  input  logic                         clk,
  input  logic                         rst_b,
  input  logic                         req_valid,
  output logic                         req_ready,
  input  logic                         req_write,
  input  logic [ADDRESS_WORD_SIZE-1:0] req_addr,
  input  logic [7:0]                   req_wdata,
  output logic [ADDRESS_WORD_SIZE-1:0] address_word,
  output logic                         try_read,
  output logic                         try_write,
  output logic [7:0]                   write_data,
  input  logic                         hit_miss,
  input  logic [3:0]                   hit_miss_set,
  input  logic [7:0]                   ages,
  input  logic                         victim_dirty,
  input  logic [TAG_SIZE-1:0]          victim_tag,
  input  logic [7:0]                   victim_rdata,
  output logic [3:0]                   reset_age,
  output logic [3:0]                   increment_age,
  output logic                         fill_we,
  output logic [3:0]                   fill_way,
  output logic [$clog2(BLOCK_SIZE)-1:0] fill_offset,
  output logic                         mem_req,
  output logic                         mem_we,
  output logic [ADDRESS_WORD_SIZE-1:0] mem_addr,
  output logic [7:0]                   mem_wdata,
  input  logic [7:0]                   mem_rdata,
  input  logic                         mem_ack,
  output logic                         done,
  output logic                         resp_hit
);

  localparam int OFFSET_BITS = $clog2(BLOCK_SIZE);
  localparam int SET_BITS    = $clog2(NUMBER_OF_SETS);

  typedef enum logic [2:0] {
    IDLE, LOOKUP, WRITEBACK, REFILL, ACCESS, DONE
  } state_t;

  state_t                         state_q, state_d;
  logic [OFFSET_BITS-1:0]         beat_q;
  logic [ADDRESS_WORD_SIZE-1:0]   addr_q;
  logic                           write_q;
  logic [7:0]                     wdata_q;
  logic                           hit_q;
  logic [3:0]                     way_q;
  logic [TAG_SIZE-1:0]            vtag_q;

  logic [1:0] best_idx, best_age;
  logic [3:0] victim_way;
  logic [1:0] way_idx, way_age;
  logic [3:0] age_inc;
  logic       last_beat;

  // Tag sits in the top bits and set/offset in the low bits; any bits between
  // them are not part of a line address and are driven as zero.
  function automatic logic [ADDRESS_WORD_SIZE-1:0] line_addr(
    input logic [TAG_SIZE-1:0]    tag,
    input logic [SET_BITS-1:0]    set,
    input logic [OFFSET_BITS-1:0] beat
  );
    logic [ADDRESS_WORD_SIZE-1:0] a;
    a = '0;
    a[ADDRESS_WORD_SIZE-1 -: TAG_SIZE] = tag;
    a[OFFSET_BITS +: SET_BITS]         = set;
    a[OFFSET_BITS-1:0]                 = beat;
    return a;
  endfunction

  // Strict compare keeps the lowest index among equal maximum ages.
  always_comb begin
    best_idx = 2'd0;
    best_age = ages[1:0];
    for (int i = 1; i < 4; i++) begin
      if (ages[2*i +: 2] > best_age) begin
        best_idx = 2'(i);
        best_age = ages[2*i +: 2];
      end
    end
    victim_way = 4'b0001 << best_idx;
  end

  always_comb begin
    way_idx = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (way_q[i]) way_idx = 2'(i);
    end
    way_age = ages[{way_idx, 1'b0} +: 2];
    for (int i = 0; i < 4; i++) begin
      age_inc[i] = !way_q[i] && (ages[2*i +: 2] < way_age);
    end
  end

  assign last_beat = &beat_q;

  always_ff @(posedge clk or posedge rst_b) begin
    if (rst_b) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d       = state_q;
    req_ready     = 1'b0;
    address_word  = '0;
    try_read      = 1'b0;
    try_write     = 1'b0;
    write_data    = '0;
    reset_age     = '0;
    increment_age = '0;
    fill_we       = 1'b0;
    fill_way      = '0;
    fill_offset   = '0;
    mem_req       = 1'b0;
    mem_we        = 1'b0;
    mem_addr      = '0;
    mem_wdata     = '0;
    done          = 1'b0;
    resp_hit      = 1'b0;
    case (state_q)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) state_d = LOOKUP;
      end
      LOOKUP: begin
        try_read     = 1'b1;
        address_word = addr_q;
        if (hit_miss)          state_d = ACCESS;
        else if (victim_dirty) state_d = WRITEBACK;
        else                   state_d = REFILL;
      end
      WRITEBACK: begin
        mem_req     = 1'b1;
        mem_we      = 1'b1;
        mem_addr    = line_addr(vtag_q, addr_q[OFFSET_BITS +: SET_BITS], beat_q);
        mem_wdata   = victim_rdata;
        fill_way    = way_q;
        fill_offset = beat_q;
        if (mem_ack && last_beat) state_d = REFILL;
      end
      REFILL: begin
        mem_req     = 1'b1;
        mem_addr    = line_addr(addr_q[ADDRESS_WORD_SIZE-1 -: TAG_SIZE],
                                addr_q[OFFSET_BITS +: SET_BITS], beat_q);
        fill_way    = way_q;
        fill_offset = beat_q;
        fill_we     = mem_ack;
        write_data  = mem_rdata;
        if (mem_ack && last_beat) state_d = ACCESS;
      end
      ACCESS: begin
        address_word  = addr_q;
        try_read      = !write_q;
        try_write     = write_q;
        write_data    = wdata_q;
        reset_age     = way_q;
        increment_age = age_inc;
        state_d       = DONE;
      end
      DONE: begin
        done     = 1'b1;
        resp_hit = hit_q;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // The beat counter wraps back to zero at the end of writeback, so the
  // refill phase always starts at beat 0.
  always_ff @(posedge clk or posedge rst_b) begin
    if (rst_b) begin
      beat_q  <= '0;
      addr_q  <= '0;
      write_q <= 1'b0;
      wdata_q <= '0;
      hit_q   <= 1'b0;
      way_q   <= '0;
      vtag_q  <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (req_valid) begin
            write_q <= req_write;
            addr_q  <= req_addr;
            wdata_q <= req_wdata;
          end
        end
        LOOKUP: begin
          beat_q <= '0;
          if (hit_miss) begin
            way_q <= hit_miss_set;
            hit_q <= 1'b1;
          end else begin
            way_q  <= victim_way;
            vtag_q <= victim_tag;
            hit_q  <= 1'b0;
          end
        end
        WRITEBACK, REFILL: begin
          if (mem_ack) beat_q <= beat_q + 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule
